fsk_period_meter: RTL and testbench

FSK_PERIOD_METER -- requirements
Module: fsk_period_meter

---
 rtl/fsk_period_meter.sv | 117 +++++++++++
 tb/tb_fsk_period_meter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fsk_period_meter.sv
// Purpose : measures the period of an FSK square wave between rising edges and
//           decodes mark/space from it; reports a no-signal timeout.
// Latency : result/result_stb update 4 clk after the pin edge (2 sync + 1 detect + 1 register).
// Backpr. : none; result is a polled status word, each update overwrites the last.
// Ports   : clk, reset (sync, active-high), sig_in (async pin), enable (level),
//           result {seq[1:0], timeout, symbol, period[27:0]}, result_stb (1-clk pulse).
module fsk_period_meter #(
   parameter logic [27:0] THRESH  = 28'd2500,
   parameter logic [27:0] TIMEOUT = 28'd1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sig_in,
   input  logic        enable,
   output logic [31:0] result,
   output logic        result_stb
);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   state_t      state_q, state_d;
   logic [27:0] cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        stb_q, stb_d;

   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        prev_q, prev_d;
   logic        edge_q, edge_d;
   logic [1:0]  fill_q, fill_d;

   // Edge detector. The sync chain and prev both reset to 0, so a pin that is
   // already high at reset release would look like a rising edge. fill_q counts
   // the clocks needed for prev to hold a genuine post-reset sample; edges are
   // masked until then.
   always_comb begin
      sync1_d = sig_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
      edge_d  = sync2_q & ~prev_q & (fill_q == 2'd3);
   end

   // Measurement FSM. seq lives in result_q[31:30] so reset of result also
   // restarts the sequence at 0 (first update carries seq = 1).
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      stb_d    = 1'b0;
      if (!enable) begin
         // Partial period is discarded, result left untouched.
         state_d = IDLE;
         cnt_d   = 28'd0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d   = 28'd0;
               state_d = ARM;
            end
            ARM: begin
               if (edge_q) begin
                  state_d = MEASURE;
                  cnt_d   = 28'd1;
               end
            end
            MEASURE: begin
               // An edge wins over a simultaneous timeout.
               if (edge_q) begin
                  result_d = {result_q[31:30] + 2'd1, 1'b0, (cnt_q < THRESH), cnt_q};
                  stb_d    = 1'b1;
                  cnt_d    = 28'd1;
               end else if (cnt_q >= TIMEOUT) begin
                  result_d = {result_q[31:30] + 2'd1, 1'b1, 1'b0, TIMEOUT};
                  stb_d    = 1'b1;
                  cnt_d    = 28'd0;
                  state_d  = ARM;
               end else begin
                  cnt_d = cnt_q + 28'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 28'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 28'd0;
         result_q <= 32'h0;
         stb_q    <= 1'b0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         prev_q   <= 1'b0;
         edge_q   <= 1'b0;
         fill_q   <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         stb_q    <= stb_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         edge_q   <= edge_d;
         fill_q   <= fill_d;
      end
   end

   assign result     = result_q;
   assign result_stb = stb_q;

endmodule

// File: tb/tb_fsk_period_meter.sv
// Purpose : randomized/directed bench for fsk_period_meter against a period-list model.
// Latency : checks every non-timeout strobe arrives 4 clk after its pin edge.
// Backpr. : n/a.
module tb_fsk_period_meter;

   localparam int THRESH_T  = 2500;
   localparam int TIMEOUT_T = 5200;

   logic        clk = 1'b0;
   logic        reset;
   logic        sig_in;
   logic        enable;
   logic [31:0] result;
   logic        result_stb;

   fsk_period_meter #(
      .THRESH (28'(THRESH_T)),
      .TIMEOUT(28'(TIMEOUT_T))
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sig_in    (sig_in),
      .enable    (enable),
      .result    (result),
      .result_stb(result_stb)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          last_rise = 0;
   logic [31:0] got_q[$];
   int          lat_q[$];
   logic [31:0] exp_q[$];
   int          ivq[$];
   logic [1:0]  m_seq = 2'd0;
   logic [31:0] last_exp = 32'h0;

   always @(posedge clk) cyc = cyc + 1;

   always @(posedge clk) begin
      #1;
      if (result_stb) begin
         got_q.push_back(result);
         lat_q.push_back(cyc - last_rise);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: every measured interval yields one update; an interval longer
   // than TIMEOUT yields a timeout instead, and the edge closing it only re-arms.
   task automatic model_push(input bit to, input int d);
      logic [27:0] p;
      m_seq = m_seq + 2'd1;
      p = to ? 28'(TIMEOUT_T) : 28'(d);
      last_exp = {m_seq, to, (!to && d < THRESH_T), p};
      exp_q.push_back(last_exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One rising edge on the pin followed by d-1 further clocks (d total).
   task automatic rise_and_wait(input int d);
      int h;
      h = d / 2;
      @(negedge clk);
      sig_in = 1'b1;
      last_rise = cyc;
      repeat (h - 1) @(negedge clk);
      @(negedge clk);
      sig_in = 1'b0;
      repeat (d - h - 1) @(negedge clk);
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_res%0d", tag, i), got_q[i], exp_q[i]);
         if (!exp_q[i][29])
            check($sformatf("%s_lat%0d", tag, i), 32'(lat_q[i]), 32'd4);
      end
      got_q.delete();
      lat_q.delete();
      exp_q.delete();
   endtask

   // Enable, drive intervals from ivq, a final rise and tail, then disable.
   task automatic run_seq(input string tag, input int tail);
      enable = 1'b1;
      idle(3);
      foreach (ivq[i]) begin
         rise_and_wait(ivq[i]);
         model_push(ivq[i] > TIMEOUT_T, ivq[i]);
      end
      rise_and_wait(tail);
      if (tail > TIMEOUT_T) model_push(1'b1, tail);
      @(negedge clk);
      enable = 1'b0;
      idle(5);
      compare_all(tag);
   endtask

   initial begin
      // Reset with the pin already high and enable asserted.
      reset = 1'b1; sig_in = 1'b1; enable = 1'b1;
      idle(3);
      check("rst_result", result, 32'h0);
      check("rst_stb", 32'(result_stb), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle(20);
      check("rel_result", result, 32'h0);
      sig_in = 1'b0;
      idle(20);
      check("rel_nostb", 32'(got_q.size()), 32'd0);

      // Three 1000-clk periods.
      ivq = '{1000, 1000, 1000};
      enable = 1'b1;
      idle(3);
      foreach (ivq[i]) begin
         rise_and_wait(ivq[i]);
         model_push(1'b0, ivq[i]);
      end
      rise_and_wait(20);
      check("first_word", got_q.size() > 0 ? got_q[0] : 32'hdead_beef, 32'h5000_03E8);
      @(negedge clk);
      enable = 1'b0;
      idle(5);
      compare_all("p1000");

      // Threshold boundaries.
      ivq = '{5000, 2500, 2499, 2501};
      run_seq("thresh", 20);

      // Timeout: over-long interval, re-arm, then a normal period; exact-TIMEOUT edge.
      ivq = '{TIMEOUT_T + 100, 800, TIMEOUT_T, 900};
      run_seq("tmo", 20);
      ivq = '{};
      run_seq("tmo_tail", TIMEOUT_T + 50);

      // Seq wrap over five periods.
      ivq = '{1000, 1000, 1000, 1000, 1000};
      run_seq("wrap", 20);

      // Enable dropped mid-period: nothing reported, result held.
      ivq = '{};
      run_seq("endrop", 500);
      check("endrop_hold", result, last_exp);
      ivq = '{700};
      run_seq("enback", 20);

      // Random periods.
      ivq = '{};
      for (int i = 0; i < 5; i++) ivq.push_back(int'($urandom_range(10, 2800)));
      run_seq("rand", 20);

      // Reset in the middle of a measurement.
      enable = 1'b1;
      idle(3);
      rise_and_wait(300);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_result", result, 32'h0);
      check("midrst_stb", 32'(result_stb), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      m_seq = 2'd0;
      got_q.delete();
      lat_q.delete();
      ivq = '{1000, 1000, 1000};
      run_seq("postrst", 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
